// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a double-buffered digit store.
// Define SEG_LEADING_ZERO_BLANK_EN to keep leading-zero digits dark during their slot.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIV          = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_idx,
    input  logic [3:0]                    wr_data,
    input  logic                          commit,
    output logic                          commit_ack,
    output logic [3:0]                    bcd_out,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
    output logic                          frame_done
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]         CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [IW:0]           DIGITS     = (IW+1)'(NUM_DIGITS);
    localparam logic                  SHOW_ONE   = (DIV - BLANK_CYCLES == 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = '1;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [3:0]            active [NUM_DIGITS];
    logic [3:0]            shadow [NUM_DIGITS];
    logic                  pending;
    logic                  copy;
    logic [IW-1:0]         idx_next;
    logic [IW-1:0]         load_idx;
    logic [3:0]            load_val;
    logic [NUM_DIGITS-1:0] lz_blank;

    function automatic logic [NUM_DIGITS-1:0] anode_on(input logic [IW-1:0] idx,
                                                        input logic [NUM_DIGITS-1:0] mask);
        logic [NUM_DIGITS-1:0] onehot;
        onehot = NUM_DIGITS'(1) << idx;
        return ~(onehot & ~mask);
    endfunction

    // The copy only happens at a frame boundary (or while idle), so the slot
    // being loaded is always digit 0 and must see the freshly committed value.
    assign copy     = pending && (state == IDLE || frame_done);
    assign idx_next = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    assign load_idx = (state == IDLE) ? '0 : idx_next;
    assign load_val = copy ? shadow[load_idx] : active[load_idx];

    always_comb begin
        lz_blank = '0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        begin
            logic run;
            run = 1'b1;
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                run         = run && (active[i] == 4'd0);
                lz_blank[i] = run;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            scan_idx   <= '0;
            bcd_out    <= 4'd0;
            an_n       <= AN_OFF;
            frame_done <= 1'b0;
        end else if (!en) begin
            state      <= IDLE;
            cnt        <= '0;
            scan_idx   <= '0;
            an_n       <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= BLANK;
                    cnt        <= '0;
                    scan_idx   <= '0;
                    bcd_out    <= load_val;
                    an_n       <= AN_OFF;
                    frame_done <= 1'b0;
                end
                BLANK: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == BLANK_LAST) begin
                        state      <= SHOW;
                        an_n       <= anode_on(scan_idx, lz_blank);
                        frame_done <= (scan_idx == IDX_LAST) && SHOW_ONE;
                    end
                end
                SHOW: begin
                    if (cnt == CNT_LAST) begin
                        state      <= BLANK;
                        cnt        <= '0;
                        scan_idx   <= idx_next;
                        bcd_out    <= load_val;
                        an_n       <= AN_OFF;
                        frame_done <= 1'b0;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        frame_done <= (scan_idx == IDX_LAST) && (cnt + 1'b1 == CNT_LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write port and commit handshake; wr_ready always mirrors !pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            wr_ready   <= 1'b1;
            commit_ack <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active[i] <= 4'd0;
                shadow[i] <= 4'd0;
            end
        end else begin
            commit_ack <= 1'b0;
            if (wr_valid && wr_ready && ({1'b0, wr_idx} < DIGITS))
                shadow[wr_idx] <= wr_data;
            if (copy) begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    active[i] <= shadow[i];
                pending    <= 1'b0;
                wr_ready   <= 1'b1;
                commit_ack <= 1'b1;
            end else if (commit && !pending) begin
                pending  <= 1'b1;
                wr_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 4-cycle slots, 1 blank cycle).
module tb_seg_scan_ctrl;
    localparam int ND = 4;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       wr_valid = 1'b0;
    logic       commit = 1'b0;
    logic [1:0] wr_idx = 2'd0;
    logic [3:0] wr_data = 4'd0;
    logic       wr_ready, commit_ack, frame_done;
    logic [3:0] bcd_out, an_n;
    logic [1:0] scan_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV(4), .BLANK_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_data(wr_data),
        .commit(commit), .commit_ack(commit_ack),
        .bcd_out(bcd_out), .an_n(an_n), .scan_idx(scan_idx), .frame_done(frame_done)
    );

    typedef struct {
        logic [3:0] an_n;
        logic [1:0] idx;
        logic [3:0] bcd;
        logic       fd;
        logic       rdy;
        logic       ack;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [3:0] an_n;
        logic [1:0] idx;
        logic [3:0] bcd;
        logic       fd;
        logic       ack;
    } vec_t;
    vec_t tbl[16];

    // Model state: m_pos is the cycle position within a 16-cycle frame, -1 when idle.
    int         m_pos;
    logic [3:0] m_act[ND];
    logic [3:0] m_sh[ND];
    logic       m_pend;
    logic [3:0] m_bcd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic lz(input int d);
        logic res;
        res = (d != 0);
        for (int j = d; j < ND; j++)
            if (m_act[j] != 4'd0) res = 1'b0;
        return res && LZ_EN;
    endfunction

    task automatic model_reset();
        m_pos  = -1;
        m_pend = 1'b0;
        m_bcd  = 4'd0;
        for (int i = 0; i < ND; i++) begin
            m_act[i] = 4'd0;
            m_sh[i]  = 4'd0;
        end
    endtask

    task automatic model_step();
        exp_t e;
        logic cp;
        logic ack;
        int   d;
        cp = m_pend && (m_pos < 0 || m_pos == 15);
        if (wr_valid && !m_pend) m_sh[wr_idx] = wr_data;
        ack = 1'b0;
        if (cp) begin
            m_act  = m_sh;
            m_pend = 1'b0;
            ack    = 1'b1;
        end else if (commit) begin
            m_pend = 1'b1;
        end
        if (!en)            m_pos = -1;
        else if (m_pos < 0) m_pos = 0;
        else                m_pos = (m_pos + 1) % 16;
        e.an_n = 4'hF;
        e.idx  = 2'd0;
        e.fd   = 1'b0;
        if (m_pos >= 0) begin
            d      = m_pos / 4;
            e.idx  = d[1:0];
            m_bcd  = m_act[d];
            e.fd   = (m_pos == 15);
            if ((m_pos % 4) != 0 && !lz(d)) e.an_n = ~(4'b0001 << d);
        end
        e.bcd = m_bcd;
        e.rdy = !m_pend;
        e.ack = ack;
        sbq.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        @(negedge clk);
        e = sbq.pop_front();
        chk("an_n", an_n, e.an_n);
        chk("scan_idx", scan_idx, e.idx);
        chk("bcd_out", bcd_out, e.bcd);
        chk("frame_done", frame_done, e.fd);
        chk("wr_ready", wr_ready, e.rdy);
        chk("commit_ack", commit_ack, e.ack);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic run_to(input int p);
        int n;
        n = 0;
        while (m_pos != p && n < 64) begin
            tick();
            n++;
        end
        if (m_pos != p) begin
            checks++;
            errors++;
            $display("FAIL run_to: position %0d not reached within bound, at %0d", p, m_pos);
        end
    endtask

    task automatic wr(input logic [1:0] i, input logic [3:0] d);
        wr_valid = 1'b1;
        wr_idx   = i;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_an_n"}, an_n, 4'hF);
        chk({tag, "_bcd"}, bcd_out, 4'd0);
        chk({tag, "_idx"}, scan_idx, 2'd0);
        chk({tag, "_fd"}, frame_done, 1'b0);
        chk({tag, "_rdy"}, wr_ready, 1'b1);
        chk({tag, "_ack"}, commit_ack, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'hF, 2'd0, 4'd1, 1'b0, 1'b1};
        tbl[1]  = '{4'hE, 2'd0, 4'd1, 1'b0, 1'b0};
        tbl[2]  = '{4'hE, 2'd0, 4'd1, 1'b0, 1'b0};
        tbl[3]  = '{4'hE, 2'd0, 4'd1, 1'b0, 1'b0};
        tbl[4]  = '{4'hF, 2'd1, 4'd2, 1'b0, 1'b0};
        tbl[5]  = '{4'hD, 2'd1, 4'd2, 1'b0, 1'b0};
        tbl[6]  = '{4'hD, 2'd1, 4'd2, 1'b0, 1'b0};
        tbl[7]  = '{4'hD, 2'd1, 4'd2, 1'b0, 1'b0};
        tbl[8]  = '{4'hF, 2'd2, 4'd3, 1'b0, 1'b0};
        tbl[9]  = '{4'hB, 2'd2, 4'd3, 1'b0, 1'b0};
        tbl[10] = '{4'hB, 2'd2, 4'd3, 1'b0, 1'b0};
        tbl[11] = '{4'hB, 2'd2, 4'd3, 1'b0, 1'b0};
        tbl[12] = '{4'hF, 2'd3, 4'd4, 1'b0, 1'b0};
        tbl[13] = '{4'h7, 2'd3, 4'd4, 1'b0, 1'b0};
        tbl[14] = '{4'h7, 2'd3, 4'd4, 1'b0, 1'b0};
        tbl[15] = '{4'h7, 2'd3, 4'd4, 1'b1, 1'b0};

        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;

        // Scan with all-zero buffers, then load 1..4 and commit mid-frame.
        en = 1'b1;
        run(6);
        wr(2'd0, 4'd1);
        wr(2'd1, 4'd2);
        wr(2'd2, 4'd3);
        wr(2'd3, 4'd4);
        pulse_commit();
        run_to(15);
        chk("frame_align", frame_done, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("tbl%0d_an_n", i), an_n, tbl[i].an_n);
            chk($sformatf("tbl%0d_idx", i), scan_idx, tbl[i].idx);
            chk($sformatf("tbl%0d_bcd", i), bcd_out, tbl[i].bcd);
            chk($sformatf("tbl%0d_fd", i), frame_done, tbl[i].fd);
            chk($sformatf("tbl%0d_ack", i), commit_ack, tbl[i].ack);
        end

        // Writes are refused while a commit is pending; a second commit is ignored.
        run(2);
        pulse_commit();
        chk("rdy_pending", wr_ready, 1'b0);
        wr(2'd0, 4'd9);
        pulse_commit();
        run(24);

        // Value above 9 is stored as-is; write and commit in one cycle.
        wr(2'd2, 4'hC);
        wr_valid = 1'b1;
        wr_idx   = 2'd1;
        wr_data  = 4'd7;
        commit   = 1'b1;
        tick();
        wr_valid = 1'b0;
        commit   = 1'b0;
        run(36);

        // Drop enable mid-SHOW on digit 2, commit while idle, then restart.
        run_to(10);
        chk("show_digit2", scan_idx, 2'd2);
        en = 1'b0;
        tick();
        chk("idle_an_n", an_n, 4'hF);
        chk("idle_idx", scan_idx, 2'd0);
        wr(2'd3, 4'd8);
        pulse_commit();
        chk("idle_ack_c1", commit_ack, 1'b0);
        tick();
        chk("idle_ack_c2", commit_ack, 1'b1);
        en = 1'b1;
        run(20);

        // Leading-zero pattern {0,0,5,0}.
        wr(2'd0, 4'd0);
        wr(2'd1, 4'd5);
        wr(2'd2, 4'd0);
        wr(2'd3, 4'd0);
        pulse_commit();
        run(40);

        // Asynchronous reset mid-SHOW with a commit pending.
        wr(2'd0, 4'd3);
        run_to(6);
        pulse_commit();
        chk("pre_reset_pending", wr_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_an_n", an_n, 4'hF);
        chk("async_bcd", bcd_out, 4'd0);
        en = 1'b0;
        model_reset();
        @(negedge clk);
        chk_reset_state("rst2");
        rst_n = 1'b1;
        en = 1'b1;
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
